// File: rtl/image_process_top.sv
// Streaming 3x3 box-blur for 8-bit grayscale lines.
// Input pixels are written round-robin into four line buffers. A control FSM
// sweeps three buffered lines as sliding 3x3 windows. Each window is summed,
// divided by 9 and queued in a first-word-fall-through output FIFO. o_intr
// pulses once for every line buffer the reader releases.
module image_process_top #(
  parameter int DATA_W     = 8,
  parameter int LINE_W     = 512,
  parameter int FIFO_DEPTH = 32,
  parameter int FIFO_AFULL = 24
) (
  input  logic              axi_clk,
  input  logic              axi_reset_n,
  input  logic              i_data_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_data_ready,
  output logic              o_data_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_data_ready,
  output logic              o_intr
);

  localparam int PTR_W = $clog2(LINE_W);
  localparam int COL_W = PTR_W + 1;
  localparam int CNT_W = 12;
  localparam int SUM_W = 12;
  localparam int FA_W  = $clog2(FIFO_DEPTH);
  localparam int FC_W  = FA_W + 1;

  localparam logic [CNT_W-1:0] THREE_LINES = CNT_W'(3 * LINE_W);
  localparam logic [PTR_W-1:0] LAST_COL    = PTR_W'(LINE_W - 1);
  localparam logic [FC_W-1:0]  STALL_LVL   = FC_W'(FIFO_DEPTH - 4);
  localparam logic [FC_W-1:0]  AFULL_LVL   = FC_W'(FIFO_AFULL);

  typedef enum logic [0:0] {S_IDLE, S_READ} state_t;

  // Floor average of a 9-pixel window; the largest sum (9*255) maps to 255,
  // so the quotient always fits in DATA_W bits.
  function automatic logic [DATA_W-1:0] avg_floor(input logic [SUM_W-1:0] s);
    return DATA_W'(s / SUM_W'(9));
  endfunction

  // Storage (data only, never reset)
  logic [DATA_W-1:0] line_buf [4][LINE_W];
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];

  // Control state
  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]        wr_sel_q, wr_sel_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]        rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic              intr_q, intr_d;
  logic              vld_p1_q, vld_p1_d;
  logic              vld_p2_q, vld_p2_d;
  logic [FA_W-1:0]   fifo_wr_q, fifo_wr_d;
  logic [FA_W-1:0]   fifo_rd_q, fifo_rd_d;
  logic [FC_W-1:0]   fifo_cnt_q, fifo_cnt_d;

  // Datapath pipeline registers
  logic [SUM_W-1:0]  sum_p1_q, sum_p1_d;
  logic [DATA_W-1:0] avg_p2_q, avg_p2_d;

  // Combinational helpers
  logic              rd_en;
  logic              fifo_stall;
  logic              fifo_push;
  logic              fifo_pop;
  logic [SUM_W-1:0]  win_sum;
  logic [1:0]        row_sel;
  logic [COL_W-1:0]  col;

  assign fifo_stall   = (fifo_cnt_q >= STALL_LVL);
  assign rd_en        = (state_q == S_READ) && !fifo_stall;
  assign o_data_valid = (fifo_cnt_q != '0);
  assign o_data       = o_data_valid ? fifo_mem[fifo_rd_q] : '0;
  assign o_data_ready = !(fifo_cnt_q >= AFULL_LVL);
  assign o_intr       = intr_q;
  assign fifo_push    = vld_p2_q;
  assign fifo_pop     = o_data_valid && i_data_ready;

  // Every valid input pixel lands in the current write buffer
  always_ff @(posedge axi_clk) begin
    if (i_data_valid) begin
      line_buf[wr_sel_q][wr_ptr_q] <= i_data;
    end
  end

  // Write pointer walks one line, then moves on to the next buffer
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    wr_sel_d = wr_sel_q;
    if (i_data_valid) begin
      if (wr_ptr_q == LAST_COL) begin
        wr_ptr_d = '0;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
  end

  // Buffered-pixel count: writes add, consumed windows subtract
  always_comb begin
    pix_cnt_d = pix_cnt_q;
    case ({i_data_valid, rd_en})
      2'b10:   pix_cnt_d = pix_cnt_q + 12'd1;
      2'b01:   pix_cnt_d = pix_cnt_q - 12'd1;
      default: pix_cnt_d = pix_cnt_q;
    endcase
  end

  // Read FSM: wait for three lines, then sweep 512 windows across them
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    rd_sel_d = rd_sel_q;
    intr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pix_cnt_q >= THREE_LINES) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (rd_en) begin
          if (rd_ptr_q == LAST_COL) begin
            rd_ptr_d = '0;
            rd_sel_d = rd_sel_q + 2'd1;
            intr_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Window sum; columns past the right edge contribute zero
  always_comb begin
    win_sum = '0;
    row_sel = '0;
    col     = '0;
    for (int r = 0; r < 3; r++) begin
      row_sel = rd_sel_q + 2'(r);
      for (int c = 0; c < 3; c++) begin
        col = {1'b0, rd_ptr_q} + COL_W'(c);
        if (col < COL_W'(LINE_W)) begin
          win_sum = win_sum + SUM_W'(line_buf[row_sel][col[PTR_W-1:0]]);
        end
      end
    end
  end

  // Arithmetic pipeline next-state: p1 holds the sum, p2 the average
  always_comb begin
    vld_p1_d = rd_en;
    sum_p1_d = win_sum;
    vld_p2_d = vld_p1_q;
    avg_p2_d = avg_floor(sum_p1_q);
  end

  // Output FIFO pointers and occupancy
  always_comb begin
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    if (fifo_push) begin
      fifo_wr_d = fifo_wr_q + 1'b1;
    end
    if (fifo_pop) begin
      fifo_rd_d = fifo_rd_q + 1'b1;
    end
    case ({fifo_push, fifo_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  // FIFO storage write from the last pipeline stage
  always_ff @(posedge axi_clk) begin
    if (fifo_push) begin
      fifo_mem[fifo_wr_q] <= avg_p2_q;
    end
  end

  // Control registers with asynchronous reset
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      wr_sel_q   <= '0;
      rd_ptr_q   <= '0;
      rd_sel_q   <= '0;
      pix_cnt_q  <= '0;
      intr_q     <= 1'b0;
      vld_p1_q   <= 1'b0;
      vld_p2_q   <= 1'b0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_sel_q   <= wr_sel_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_sel_q   <= rd_sel_d;
      pix_cnt_q  <= pix_cnt_d;
      intr_q     <= intr_d;
      vld_p1_q   <= vld_p1_d;
      vld_p2_q   <= vld_p2_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // ---- stage p1 -> p2 data registers (qualified by vld_p1/vld_p2) ----
  always_ff @(posedge axi_clk) begin
    sum_p1_q <= sum_p1_d;
    avg_p2_q <= avg_p2_d;
  end

endmodule

// File: tb/tb_image_process_top.sv
// Directed bench for image_process_top: reset, constant and max-value lines,
// the three-line read threshold and its latency, and a multi-line ramp image
// under output backpressure followed by the o_intr line-refill protocol.
module tb_image_process_top;

  logic       axi_clk;
  logic       axi_reset_n;
  logic       i_data_valid;
  logic [7:0] i_data;
  logic       o_data_ready;
  logic       o_data_valid;
  logic [7:0] o_data;
  logic       i_data_ready;
  logic       o_intr;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int out_cnt  = 0;
  int intr_cnt = 0;

  logic [7:0] img [6][512];

  image_process_top dut (
    .axi_clk      (axi_clk),
    .axi_reset_n  (axi_reset_n),
    .i_data_valid (i_data_valid),
    .i_data       (i_data),
    .o_data_ready (o_data_ready),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .i_data_ready (i_data_ready),
    .o_intr       (o_intr)
  );

  initial axi_clk = 1'b0;
  always #5 axi_clk = ~axi_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Reference: output k is row k/512, column k%512, zero beyond column 511
  function automatic logic [7:0] exp_pix(input int k);
    int row, col, sum;
    row = k / 512;
    col = k % 512;
    sum = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        if ((col + dc) < 512 && (row + dr) < 6)
          sum += int'(img[row + dr][col + dc]);
    return 8'(sum / 9);
  endfunction

  // Observe outputs before the coming edge (pop happens there), then advance
  task automatic tick();
    if (o_data_valid && i_data_ready) begin
      check($sformatf("pix%0d", out_cnt), o_data, exp_pix(out_cnt));
      out_cnt++;
    end
    if (o_intr) intr_cnt++;
    @(posedge axi_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_line(input int l);
    for (int c = 0; c < 512; c++) begin
      i_data_valid = 1'b1;
      i_data       = img[l][c];
      tick();
    end
    i_data_valid = 1'b0;
    i_data       = 8'd0;
  endtask

  task automatic wait_intr(input int target, input int budget);
    int n;
    n = 0;
    while (intr_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("intr_reach%0d", target), intr_cnt, target);
  endtask

  task automatic wait_out(input int target, input int budget);
    int n;
    n = 0;
    while (out_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check($sformatf("out_reach%0d", target), out_cnt, target);
  endtask

  task automatic do_reset();
    i_data_valid = 1'b0;
    i_data       = 8'd0;
    axi_reset_n  = 1'b0;
    idle(3);
    axi_reset_n  = 1'b1;
    out_cnt      = 0;
    intr_cnt     = 0;
    idle(2);
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int l = 0; l < 6; l++)
      for (int c = 0; c < 512; c++)
        img[l][c] = (l < 4) ? v : 8'd0;
  endtask

  task automatic run_const(input logic [7:0] v);
    do_reset();
    fill_const(v);
    for (int l = 0; l < 4; l++) send_line(l);
    wait_out(1024, 3000);
    idle(10);
    check($sformatf("const%0d_intr", v), intr_cnt, 2);
    check($sformatf("const%0d_outs", v), out_cnt, 1024);
    check($sformatf("const%0d_empty", v), o_data_valid, 0);
  endtask

  initial begin
    i_data_valid = 1'b0;
    i_data       = 8'd0;
    i_data_ready = 1'b1;
    axi_reset_n  = 1'b0;

    // Reset held for 10 cycles
    idle(10);
    check("rst_intr", o_intr, 0);
    check("rst_valid", o_data_valid, 0);
    check("rst_ready", o_data_ready, 1);
    check("rst_data", o_data, 0);
    axi_reset_n = 1'b1;
    idle(20);
    check("post_rst_valid", o_data_valid, 0);
    check("post_rst_outs", out_cnt, 0);
    check("post_rst_intr", intr_cnt, 0);

    // Constant 90: interior 90, column 510 -> 60, column 511 -> 30
    run_const(8'd90);
    // All 255: interior 255, column 510 -> 170, column 511 -> 85
    run_const(8'd255);

    // Threshold: 1535 pixels must not start a read
    do_reset();
    fill_const(8'd9);
    for (int k = 0; k < 1535; k++) begin
      i_data_valid = 1'b1;
      i_data       = img[k / 512][k % 512];
      tick();
    end
    i_data_valid = 1'b0;
    idle(30);
    check("thr_noread_valid", o_data_valid, 0);
    check("thr_noread_outs", out_cnt, 0);
    i_data_valid = 1'b1;
    i_data       = 8'd9;
    tick();
    i_data_valid = 1'b0;
    i_data       = 8'd0;
    idle(3);
    check("thr_lat3_valid", o_data_valid, 0);
    tick();
    check("thr_lat4_valid", o_data_valid, 1);
    check("thr_lat4_data", o_data, 9);
    wait_out(512, 2000);
    wait_intr(1, 100);
    idle(20);
    check("thr_stop_outs", out_cnt, 512);
    check("thr_stop_intr", intr_cnt, 1);

    // Ramp image under backpressure, then the o_intr refill protocol
    do_reset();
    for (int l = 0; l < 6; l++)
      for (int c = 0; c < 512; c++)
        img[l][c] = (l < 5) ? 8'((l * 7 + c * 3) & 255) : 8'd0;
    i_data_ready = 1'b0;
    for (int l = 0; l < 4; l++) send_line(l);
    check("bp_ready_low", o_data_ready, 0);
    check("bp_valid", o_data_valid, 1);
    check("bp_no_intr", intr_cnt, 0);
    idle(50);
    check("bp_ready_still_low", o_data_ready, 0);
    check("bp_no_pop", out_cnt, 0);
    i_data_ready = 1'b1;
    wait_intr(1, 3000);
    send_line(4);
    wait_intr(2, 3000);
    send_line(5);
    wait_out(2048, 5000);
    idle(20);
    check("flow_intr_total", intr_cnt, 4);
    check("flow_outs_total", out_cnt, 2048);
    check("flow_ready_high", o_data_ready, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
